// File: rtl/punc_ctrl_pkg.sv
// Shared definitions for the PUnC control unit and datapath: FSM states,
// LC3 opcodes, datapath select encodings and the packed control word.
package punc_ctrl_pkg;

   localparam int unsigned IR_W       = 16;
   localparam int unsigned OP_W       = 4;
   localparam int unsigned STATE_W    = 3;
   localparam int unsigned SEL2_W     = 2;
   localparam int unsigned ALU_B_W    = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_EXEC2  = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   // LC3 opcodes (ir[15:12])
   localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
   localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
   localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
   localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
   localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
   localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
   localparam logic [OP_W-1:0] OP_RSV8 = 4'b1000;
   localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
   localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
   localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
   localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
   localparam logic [OP_W-1:0] OP_RSVD = 4'b1101;
   localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
   localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

   // PC mux
   localparam logic [SEL2_W-1:0] PC_SEL_PC1 = 2'd0;
   localparam logic [SEL2_W-1:0] PC_SEL_ALU = 2'd1;
   localparam logic [SEL2_W-1:0] PC_SEL_RF0 = 2'd2;

   // memory read address mux
   localparam logic [SEL2_W-1:0] MEM_RADDR_PC  = 2'd0;
   localparam logic [SEL2_W-1:0] MEM_RADDR_ALU = 2'd1;
   localparam logic [SEL2_W-1:0] MEM_RADDR_IND = 2'd2;

   // memory write address mux (write data is always RF read 1)
   localparam logic MEM_WADDR_ALU = 1'b0;
   localparam logic MEM_WADDR_IND = 1'b1;

   // register file address/data muxes
   localparam logic REG_RADDR0_IR86  = 1'b0;
   localparam logic REG_RADDR0_IR119 = 1'b1;
   localparam logic REG_RADDR1_IR20  = 1'b0;
   localparam logic REG_RADDR1_IR119 = 1'b1;
   localparam logic REG_WADDR_IR119  = 1'b0;
   localparam logic REG_WADDR_R7     = 1'b1;
   localparam logic [SEL2_W-1:0] REG_WDATA_ALU = 2'd0;
   localparam logic [SEL2_W-1:0] REG_WDATA_MEM = 2'd1;
   localparam logic [SEL2_W-1:0] REG_WDATA_PC  = 2'd2;

   // ALU operand and operation selects
   localparam logic ALU_A_RF0 = 1'b0;
   localparam logic ALU_A_PC  = 1'b1;
   localparam logic [ALU_B_W-1:0] ALU_B_RF1     = 3'd0;
   localparam logic [ALU_B_W-1:0] ALU_B_IMM5    = 3'd1;
   localparam logic [ALU_B_W-1:0] ALU_B_OFF6    = 3'd2;
   localparam logic [ALU_B_W-1:0] ALU_B_PCOFF9  = 3'd3;
   localparam logic [ALU_B_W-1:0] ALU_B_PCOFF11 = 3'd4;
   localparam logic [SEL2_W-1:0] ALU_OP_ADD = 2'd0;
   localparam logic [SEL2_W-1:0] ALU_OP_AND = 2'd1;
   localparam logic [SEL2_W-1:0] ALU_OP_NOT = 2'd2;

   // condition-code source
   localparam logic CC_SRC_ALU = 1'b0;
   localparam logic CC_SRC_MEM = 1'b1;

   // every strobe and select the datapath consumes
   typedef struct packed {
      logic               ir_ld;
      logic               pc_ld;
      logic [SEL2_W-1:0]  pc_sel;
      logic [SEL2_W-1:0]  mem_raddr_sel;
      logic               mem_waddr_sel;
      logic               mem_w_en;
      logic               reg_raddr0_sel;
      logic               reg_raddr1_sel;
      logic               reg_waddr_sel;
      logic [SEL2_W-1:0]  reg_wdata_sel;
      logic               reg_w_en;
      logic               alu_a_sel;
      logic [ALU_B_W-1:0] alu_b_sel;
      logic [SEL2_W-1:0]  alu_op;
      logic               cc_ld;
      logic               cc_src_sel;
      logic               ind_ld;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   // BR condition: any requested flag that is currently set
   function automatic logic br_taken(input logic [2:0] cond, input logic n,
                                     input logic z, input logic p);
      return (cond[2] & n) | (cond[1] & z) | (cond[0] & p);
   endfunction

endpackage

// File: rtl/punc_decode.sv
// Combinational opcode decoder: produces the EXEC or EXEC2 control word for
// the current instruction plus the flags the FSM needs to sequence it.
module punc_decode
   import punc_ctrl_pkg::*;
#(
   parameter bit HALT_ON_RESERVED = 1'b1
) (
   input  logic [IR_W-1:0] ir_i,
   input  logic            n_i,
   input  logic            z_i,
   input  logic            p_i,
   input  logic            exec2_i,
   output ctrl_t           ctrl_c_o,
   output logic            two_phase_c_o,
   output logic            halt_c_o
);

   logic [OP_W-1:0] op;
   logic            unused_ir;

   assign op = ir_i[15:12];

   // register fields ir[8:6] and ir[2:0] are steered by the datapath directly
   assign unused_ir = ^{ir_i[8:6], ir_i[4:0]};

   // opcode to control word; EXEC2 word only differs for LDI/STI
   always_comb begin
      ctrl_c_o      = CTRL_NONE;
      two_phase_c_o = 1'b0;
      halt_c_o      = 1'b0;
      case (op)
         OP_ADD, OP_AND: begin
            ctrl_c_o.alu_a_sel  = ALU_A_RF0;
            ctrl_c_o.alu_b_sel  = ir_i[5] ? ALU_B_IMM5 : ALU_B_RF1;
            ctrl_c_o.alu_op     = (op == OP_AND) ? ALU_OP_AND : ALU_OP_ADD;
            ctrl_c_o.reg_waddr_sel = REG_WADDR_IR119;
            ctrl_c_o.reg_wdata_sel = REG_WDATA_ALU;
            ctrl_c_o.reg_w_en   = 1'b1;
            ctrl_c_o.cc_ld      = 1'b1;
            ctrl_c_o.cc_src_sel = CC_SRC_ALU;
         end
         OP_NOT: begin
            ctrl_c_o.alu_op     = ALU_OP_NOT;
            ctrl_c_o.reg_w_en   = 1'b1;
            ctrl_c_o.cc_ld      = 1'b1;
            ctrl_c_o.cc_src_sel = CC_SRC_ALU;
         end
         OP_BR: begin
            if (br_taken(ir_i[11:9], n_i, z_i, p_i)) begin
               ctrl_c_o.pc_ld     = 1'b1;
               ctrl_c_o.pc_sel    = PC_SEL_ALU;
               ctrl_c_o.alu_a_sel = ALU_A_PC;
               ctrl_c_o.alu_b_sel = ALU_B_PCOFF9;
            end
         end
         OP_JMP: begin
            ctrl_c_o.pc_ld          = 1'b1;
            ctrl_c_o.pc_sel         = PC_SEL_RF0;
            ctrl_c_o.reg_raddr0_sel = REG_RADDR0_IR86;
         end
         OP_JSR: begin
            // link and jump on one edge; JSRR R7 reads the pre-edge R7
            ctrl_c_o.pc_ld         = 1'b1;
            ctrl_c_o.reg_waddr_sel = REG_WADDR_R7;
            ctrl_c_o.reg_wdata_sel = REG_WDATA_PC;
            ctrl_c_o.reg_w_en      = 1'b1;
            if (ir_i[11]) begin
               ctrl_c_o.pc_sel    = PC_SEL_ALU;
               ctrl_c_o.alu_a_sel = ALU_A_PC;
               ctrl_c_o.alu_b_sel = ALU_B_PCOFF11;
            end else begin
               ctrl_c_o.pc_sel         = PC_SEL_RF0;
               ctrl_c_o.reg_raddr0_sel = REG_RADDR0_IR86;
            end
         end
         OP_LD, OP_LDR: begin
            ctrl_c_o.alu_a_sel     = (op == OP_LD) ? ALU_A_PC : ALU_A_RF0;
            ctrl_c_o.alu_b_sel     = (op == OP_LD) ? ALU_B_PCOFF9 : ALU_B_OFF6;
            ctrl_c_o.mem_raddr_sel = MEM_RADDR_ALU;
            ctrl_c_o.reg_wdata_sel = REG_WDATA_MEM;
            ctrl_c_o.reg_w_en      = 1'b1;
            ctrl_c_o.cc_ld         = 1'b1;
            ctrl_c_o.cc_src_sel    = CC_SRC_MEM;
         end
         OP_LEA: begin
            ctrl_c_o.alu_a_sel     = ALU_A_PC;
            ctrl_c_o.alu_b_sel     = ALU_B_PCOFF9;
            ctrl_c_o.reg_wdata_sel = REG_WDATA_ALU;
            ctrl_c_o.reg_w_en      = 1'b1;
         end
         OP_ST, OP_STR: begin
            ctrl_c_o.alu_a_sel      = (op == OP_ST) ? ALU_A_PC : ALU_A_RF0;
            ctrl_c_o.alu_b_sel      = (op == OP_ST) ? ALU_B_PCOFF9 : ALU_B_OFF6;
            ctrl_c_o.mem_waddr_sel  = MEM_WADDR_ALU;
            ctrl_c_o.reg_raddr1_sel = REG_RADDR1_IR119;
            ctrl_c_o.mem_w_en       = 1'b1;
         end
         OP_LDI, OP_STI: begin
            two_phase_c_o = 1'b1;
            if (!exec2_i) begin
               // first access fetches the pointer into IND
               ctrl_c_o.alu_a_sel     = ALU_A_PC;
               ctrl_c_o.alu_b_sel     = ALU_B_PCOFF9;
               ctrl_c_o.mem_raddr_sel = MEM_RADDR_ALU;
               ctrl_c_o.ind_ld        = 1'b1;
            end else if (op == OP_LDI) begin
               ctrl_c_o.mem_raddr_sel = MEM_RADDR_IND;
               ctrl_c_o.reg_wdata_sel = REG_WDATA_MEM;
               ctrl_c_o.reg_w_en      = 1'b1;
               ctrl_c_o.cc_ld         = 1'b1;
               ctrl_c_o.cc_src_sel    = CC_SRC_MEM;
            end else begin
               ctrl_c_o.mem_waddr_sel  = MEM_WADDR_IND;
               ctrl_c_o.reg_raddr1_sel = REG_RADDR1_IR119;
               ctrl_c_o.mem_w_en       = 1'b1;
            end
         end
         OP_HALT: halt_c_o = 1'b1;
         OP_RSV8, OP_RSVD: halt_c_o = HALT_ON_RESERVED;
         default: ;
      endcase
   end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: sequences fetch/decode/execute and drives every
// datapath strobe and select; HALT is absorbing until reset.
module punc_control
   import punc_ctrl_pkg::*;
#(
   parameter bit HALT_ON_RESERVED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IR_W-1:0]  ir,
   input  logic             N,
   input  logic             Z,
   input  logic             P,
   output logic             ir_ld,
   output logic             pc_ld,
   output logic [1:0]       pc_sel,
   output logic [1:0]       mem_raddr_sel,
   output logic             mem_waddr_sel,
   output logic             mem_w_en,
   output logic             reg_raddr0_sel,
   output logic             reg_raddr1_sel,
   output logic             reg_waddr_sel,
   output logic [1:0]       reg_wdata_sel,
   output logic             reg_w_en,
   output logic             alu_a_sel,
   output logic [2:0]       alu_b_sel,
   output logic [1:0]       alu_op,
   output logic             cc_ld,
   output logic             cc_src_sel,
   output logic             ind_ld,
   output logic             halted
);

   state_e state_q, state_d;
   ctrl_t  exec_ctrl;
   ctrl_t  ctrl_c;
   logic   halted_c;
   logic   two_phase;
   logic   halt_op;
   logic   in_exec2;

   assign in_exec2 = (state_q == ST_EXEC2);

   punc_decode #(
      .HALT_ON_RESERVED (HALT_ON_RESERVED)
   ) u_decode (
      .ir_i          (ir),
      .n_i           (N),
      .z_i           (Z),
      .p_i           (P),
      .exec2_i       (in_exec2),
      .ctrl_c_o      (exec_ctrl),
      .two_phase_c_o (two_phase),
      .halt_c_o      (halt_op)
   );

   // state register, asynchronously forced to FETCH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_FETCH;
      else      state_q <= state_d;
   end

   // instruction sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            if (halt_op)        state_d = ST_HALT;
            else if (two_phase) state_d = ST_EXEC2;
            else                state_d = ST_FETCH;
         end
         ST_EXEC2:  state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
   end

   // control outputs; reset gates everything so no write can leak mid-instruction
   always_comb begin
      ctrl_c   = CTRL_NONE;
      halted_c = 1'b0;
      if (rst) begin
         case (state_q)
            ST_FETCH: begin
               ctrl_c.mem_raddr_sel = MEM_RADDR_PC;
               ctrl_c.ir_ld         = 1'b1;
               ctrl_c.pc_ld         = 1'b1;
               ctrl_c.pc_sel        = PC_SEL_PC1;
            end
            ST_EXEC, ST_EXEC2: ctrl_c = exec_ctrl;
            ST_HALT:           halted_c = 1'b1;
            default: ;
         endcase
      end
   end

   assign ir_ld          = ctrl_c.ir_ld;
   assign pc_ld          = ctrl_c.pc_ld;
   assign pc_sel         = ctrl_c.pc_sel;
   assign mem_raddr_sel  = ctrl_c.mem_raddr_sel;
   assign mem_waddr_sel  = ctrl_c.mem_waddr_sel;
   assign mem_w_en       = ctrl_c.mem_w_en;
   assign reg_raddr0_sel = ctrl_c.reg_raddr0_sel;
   assign reg_raddr1_sel = ctrl_c.reg_raddr1_sel;
   assign reg_waddr_sel  = ctrl_c.reg_waddr_sel;
   assign reg_wdata_sel  = ctrl_c.reg_wdata_sel;
   assign reg_w_en       = ctrl_c.reg_w_en;
   assign alu_a_sel      = ctrl_c.alu_a_sel;
   assign alu_b_sel      = ctrl_c.alu_b_sel;
   assign alu_op         = ctrl_c.alu_op;
   assign cc_ld          = ctrl_c.cc_ld;
   assign cc_src_sel     = ctrl_c.cc_src_sel;
   assign ind_ld         = ctrl_c.ind_ld;
   assign halted         = halted_c;

endmodule

// File: doc/punc_control.md
# punc_control

Control FSM for the PUnC LC3 processor, the counterpart of the PUnC datapath. It takes the instruction register and the N/Z/P condition codes from the datapath and drives every mux select, load strobe and write enable the datapath needs. It runs the fetch/decode/execute sequence for the LC3 subset (ADD, AND, NOT, BR, JMP, JSR/JSRR, LD, LDI, LDR, LEA, ST, STI, STR, HALT), and halts until reset.

## Interface
- `HALT_ON_RESERVED`, default 1: opcodes 1000 and 1101 halt when 1 and act as a NOP when 0.
- `clk` in 1: clock, all state on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ir` in 16: instruction register contents from the datapath.
- `N`, `Z`, `P` in 1 each: condition-code flops from the datapath.
- `ir_ld` out 1: load IR from memory read port 0.
- `pc_ld` out 1: load PC from the PC mux.
- `pc_sel` out 2: 0 PC+1, 1 ALU, 2 RF read 0.
- `mem_raddr_sel` out 2: 0 PC, 1 ALU, 2 IND register.
- `mem_waddr_sel` out 1: 0 ALU, 1 IND register. Write data is always RF read 1.
- `mem_w_en` out 1: memory write.
- `reg_raddr0_sel` out 1: 0 ir[8:6], 1 ir[11:9].
- `reg_raddr1_sel` out 1: 0 ir[2:0], 1 ir[11:9].
- `reg_waddr_sel` out 1: 0 ir[11:9], 1 R7.
- `reg_wdata_sel` out 2: 0 ALU, 1 memory read data, 2 PC.
- `reg_w_en` out 1: register-file write.
- `alu_a_sel` out 1: 0 RF read 0, 1 PC.
- `alu_b_sel` out 3: 0 RF read 1, 1 imm5, 2 offset6, 3 PCoffset9, 4 PCoffset11.
- `alu_op` out 2: 0 ADD, 1 AND, 2 NOT a.
- `cc_ld` out 1: update N/Z/P.
- `cc_src_sel` out 1: 0 ALU, 1 memory read data.
- `ind_ld` out 1: load the IND register from memory read data (used by LDI and STI).
- `halted` out 1: high while in HALT.

## Operation
- States:
  - FETCH → DECODE → EXEC → FETCH.
  - EXEC → EXEC2 → FETCH for LDI and STI.
  - EXEC → HALT for 1111, and for reserved opcodes when `HALT_ON_RESERVED` is 1.
  - HALT is absorbing until reset.
- Outputs are combinational from state, `ir` and N/Z/P. Any select not listed for a state is 0. All enables are 0 except where listed.
- FETCH: `mem_raddr_sel`=PC, `ir_ld`=1, `pc_ld`=1, `pc_sel`=PC+1.
- DECODE: no strobes. IR is stable here.
- EXEC, by opcode. PC already holds PC+1.
  - ADD/AND: a=RF0 (ir[8:6]); b = imm5 if ir[5] else RF1; RF[ir[11:9]] ← ALU; `cc_ld`, `cc_src_sel`=ALU.
  - NOT: `alu_op`=NOT; same register write and CC update as ADD.
  - BR: if (ir[11]&N)|(ir[10]&Z)|(ir[9]&P), then `pc_ld`, `pc_sel`=ALU, a=PC, b=PCoffset9. Otherwise no strobes.
  - JMP: `pc_ld`, `pc_sel`=RF0, `reg_raddr0_sel`=ir[8:6].
  - JSR/JSRR: R7 ← PC (`reg_waddr_sel`=R7, `reg_wdata_sel`=PC, `reg_w_en`) and `pc_ld` on the same edge.
    - ir[11]=1: `pc_sel`=ALU, a=PC, b=PCoffset11.
    - ir[11]=0: `pc_sel`=RF0.
    - JSRR with R7 as base uses the old R7, because the read is combinational before the edge.
  - LD: `mem_raddr_sel`=ALU (PC+PCoffset9); RF ← memory; `cc_ld`, `cc_src_sel`=memory.
  - LDR: same as LD with a=RF0, b=offset6.
  - LEA: RF ← PC+PCoffset9. CC is not updated.
  - ST: memory[PC+PCoffset9] ← RF1 with `reg_raddr1_sel`=ir[11:9]; `mem_w_en`.
  - STR: same as ST with a=RF0, b=offset6.
  - LDI/STI: `mem_raddr_sel`=ALU (PC+PCoffset9), `ind_ld`.
- EXEC2:
  - LDI: `mem_raddr_sel`=IND; RF ← memory; `cc_ld`, `cc_src_sel`=memory.
  - STI: `mem_waddr_sel`=IND; `mem_w_en`; `reg_raddr1_sel`=ir[11:9].
- HALT: all enables 0; `halted`=1.

## Timing
- Reset:
  - While `rst` is low, state is FETCH and every enable and select output is forced to 0. `halted` is 0.
  - This takes effect asynchronously, including mid-EXEC or mid-EXEC2. No partial write may occur.
- First cycle after `rst` rises is FETCH.
- Latency per instruction: 3 cycles; LDI and STI take 4 cycles.
- An untaken BR still spends its EXEC cycle.
- `ir` changes only on the FETCH→DECODE edge. Decode uses `ir` in DECODE, EXEC and EXEC2 only.
- N/Z/P are sampled combinationally in EXEC. A CC update from the previous instruction is already visible.
- At most one of `reg_w_en` and `mem_w_en` is high in any cycle.

## Structure
- `punc_ctrl_pkg` holds:
  - the state enum (FETCH, DECODE, EXEC, EXEC2, HALT);
  - the opcode constants;
  - every select encoding listed above.
- The datapath imports the same package.
- One sub-module, `punc_decode`: combinational opcode → EXEC/EXEC2 control word. The FSM stays in `punc_control`.

## Test plan
- Reset mid-instruction: drive `rst` low during EXEC of `ir`=16'h1263. All outputs go to 0 immediately. After release, the first cycle has `ir_ld`=1, `pc_ld`=1, `pc_sel`=0.
- ADD immediate, `ir`=16'h1263: EXEC (cycle 3) has `reg_w_en`=1, `alu_b_sel`=1, `alu_op`=0, `cc_ld`=1, `cc_src_sel`=0. Register form `ir`=16'h1042 gives `alu_b_sel`=0.
- BR:
  - `ir`=16'h0402 with Z=1: EXEC has `pc_ld`=1, `pc_sel`=1, `alu_a_sel`=1, `alu_b_sel`=3.
  - Same `ir` with Z=0, N=1: `pc_ld`=0.
  - `ir`=16'h0000: never taken.
- LDI, `ir`=16'hA205:
  - EXEC: `ind_ld`=1, `mem_raddr_sel`=1.
  - EXEC2: `mem_raddr_sel`=2, `reg_w_en`=1, `reg_wdata_sel`=1, `cc_src_sel`=1.
  - FETCH follows 4 cycles after the instruction's FETCH.
- JSR, `ir`=16'h4805: EXEC has `reg_waddr_sel`=1, `reg_wdata_sel`=2, `reg_w_en`=1, `pc_sel`=1, `alu_b_sel`=4. JSRR `ir`=16'h41C0 gives `pc_sel`=2.
- Halt:
  - `ir`=16'hF025: `halted`=1 from the cycle after EXEC, and no `ir_ld` for 10 cycles.
  - `ir`=16'hD000 with `HALT_ON_RESERVED`=0: returns to FETCH with no strobes in EXEC.
